// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle for the iterative multiply/divide unit.
//   start, alu_control, a, b : operation request (sampled while busy=0)
//   hi_we, lo_we, wdata      : mthi/mtlo register writes
//   busy, done, hi, lo       : status pulse/level and architectural HI/LO
// master = pipeline side (drives requests), slave = muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_control, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, alu_control, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/multu/div/divu with architectural HI/LO.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_if.slave (request, mthi/mtlo write, busy/done, hi/lo)
// Operation codes (alu_control): 1100 mult, 1101 multu, 1110 div, 1111 divu.
// Flow: IDLE -(accept)-> RUN (WIDTH cycles, one bit each) -> FIX -> IDLE.
// Operands are reduced to magnitudes at acceptance; FIX restores signs.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic               is_div_reg, is_div_next;
    logic               neg_lo_reg, neg_lo_next;   // negate product / quotient
    logic               neg_hi_reg, neg_hi_next;   // remainder follows dividend sign
    logic [WIDTH-1:0]   operand_reg, operand_next; // |b|: multiplicand or divisor
    logic [2*WIDTH-1:0] acc_reg, acc_next;         // mult: {partial, multiplier}; div: {rem, dividend/quot}
    logic [CW-1:0]      count_reg, count_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;

    logic               accept;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign accept    = (state_reg == IDLE) && bus.start && (bus.alu_control[3:2] == 2'b11);
    assign is_signed = ~bus.alu_control[0];
    assign a_neg     = is_signed & bus.a[WIDTH-1];
    assign b_neg     = is_signed & bus.b[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is the
    // correct magnitude, so no extra bit is needed.
    assign mag_a     = a_neg ? -bus.a : bus.a;
    assign mag_b     = b_neg ? -bus.b : bus.b;

    // Multiply step: conditionally add into the upper half, then shift right.
    assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_reg[0] ? operand_reg : {WIDTH{1'b0}})};
    // Restoring divide step: bring the next dividend bit into the remainder.
    // With a zero divisor every step subtracts nothing, so the quotient fills
    // with ones and the remainder ends as the dividend magnitude.
    assign div_cand  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_cand - {1'b0, operand_reg};

    assign prod_fix  = neg_lo_reg ? -acc_reg : acc_reg;
    assign quot      = acc_reg[WIDTH-1:0];
    assign rem       = acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next   = state_reg;
        is_div_next  = is_div_reg;
        neg_lo_next  = neg_lo_reg;
        neg_hi_next  = neg_hi_reg;
        operand_next = operand_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = RUN;
                    is_div_next  = bus.alu_control[1];
                    // A zero divisor leaves the all-ones quotient uncorrected.
                    neg_lo_next  = (a_neg ^ b_neg) && !(bus.alu_control[1] && (bus.b == '0));
                    neg_hi_next  = a_neg;
                    operand_next = mag_b;
                    acc_next     = {{WIDTH{1'b0}}, mag_a};
                    count_next   = '0;
                end else begin
                    if (bus.hi_we) hi_next = bus.wdata;
                    if (bus.lo_we) lo_next = bus.wdata;
                end
            end
            RUN: begin
                if (is_div_reg) begin
                    if (div_cand >= {1'b0, operand_reg})
                        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
                    else
                        acc_next = {div_cand[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
                end else begin
                    acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
                end
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1))
                    state_next = FIX;
            end
            FIX: begin
                if (is_div_reg) begin
                    hi_next = neg_hi_reg ? -rem : rem;
                    lo_next = neg_lo_reg ? -quot : quot;
                end else begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            is_div_reg  <= 1'b0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            operand_reg <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            is_div_reg  <= is_div_next;
            neg_lo_reg  <= neg_lo_next;
            neg_hi_reg  <= neg_hi_next;
            operand_reg <= operand_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Expected hi/lo come from plain integer arithmetic on the operands.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit w8, input logic s, input logic [3:0] c,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic hw, input logic lw, input logic [31:0] wd);
        if (w8) begin
            bus8.start = s; bus8.alu_control = c; bus8.a = av[7:0]; bus8.b = bv[7:0];
            bus8.hi_we = hw; bus8.lo_we = lw; bus8.wdata = wd[7:0];
        end else begin
            bus32.start = s; bus32.alu_control = c; bus32.a = av; bus32.b = bv;
            bus32.hi_we = hw; bus32.lo_we = lw; bus32.wdata = wd;
        end
    endtask

    function automatic logic [31:0] rd_hi(input bit w8);
        return w8 ? {24'h0, bus8.hi} : bus32.hi;
    endfunction
    function automatic logic [31:0] rd_lo(input bit w8);
        return w8 ? {24'h0, bus8.lo} : bus32.lo;
    endfunction
    function automatic logic rd_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction
    function automatic logic rd_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    // Reference: integer arithmetic on the width-w interpretation of a and b.
    task automatic model(input bit w8, input logic [3:0] c, input logic [31:0] av,
                         input logic [31:0] bv, output logic [31:0] eh, output logic [31:0] el);
        int                w;
        longint            ua, ub, sa, sb, q, r, p;
        longint unsigned   pu;
        longint            mask;
        w    = w8 ? 8 : 32;
        mask = (64'sd1 <<< w) - 64'sd1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
        sb   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
        eh   = 32'h0;
        el   = 32'h0;
        case (c)
            4'b1100: begin
                p  = sa * sb;
                eh = 32'((p >> w) & mask);
                el = 32'(p & mask);
            end
            4'b1101: begin
                pu = longint'(ua) * longint'(ub);
                eh = 32'((pu >> w) & mask);
                el = 32'(pu & mask);
            end
            4'b1110: begin
                if (ub == 0) begin
                    eh = 32'(ua); el = 32'(mask);
                end else begin
                    q = sa / sb; r = sa % sb;
                    eh = 32'(r & mask); el = 32'(q & mask);
                end
            end
            default: begin
                if (ub == 0) begin
                    eh = 32'(ua); el = 32'(mask);
                end else begin
                    eh = 32'((ua % ub) & mask); el = 32'((ua / ub) & mask);
                end
            end
        endcase
    endtask

    // mode: 0 plain, 1 start pulse during RUN, 2 hi_we/lo_we during RUN,
    //       3 hi_we/lo_we together with the accepted start.
    // b2b:  issue in the current done cycle instead of waiting for a negedge.
    task automatic run_op(input bit w8, input logic [3:0] c, input logic [31:0] av,
                          input logic [31:0] bv, input int mode, input bit b2b);
        int          w, n, busy_cnt;
        logic [31:0] eh, el, ph, pl, wd;
        w = w8 ? 8 : 32;
        model(w8, c, av, bv, eh, el);
        if (b2b) check("b2b_in_done_cycle", 64'(rd_done(w8)), 64'(1'b1));
        else @(negedge clk);
        ph = rd_hi(w8);
        pl = rd_lo(w8);
        wd = ~ph;
        set_in(w8, 1'b1, c, av, bv, mode == 3, mode == 3, wd);
        @(posedge clk); #1;
        set_in(w8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        n = 0;
        busy_cnt = 0;
        while (rd_done(w8) !== 1'b1 && n < w + 8) begin
            if (rd_busy(w8) === 1'b1) busy_cnt++;
            if (n == 1 && (mode == 1 || mode == 2))
                set_in(w8, mode == 1, 4'b1111, bv, av, mode == 2, mode == 2, wd);
            if (n == 2) set_in(w8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (n == 3) begin
                check("hold_hi_in_run", 64'(rd_hi(w8)), 64'(ph));
                check("hold_lo_in_run", 64'(rd_lo(w8)), 64'(pl));
            end
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", 64'(n), 64'(w + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(w + 1));
        check("busy_low_at_done", 64'(rd_busy(w8)), 64'(1'b0));
        check("hi", 64'(rd_hi(w8)), 64'(eh));
        check("lo", 64'(rd_lo(w8)), 64'(el));
        $display("[TB] w=%0d op=%b a=%h b=%h mode=%0d b2b=%0d -> hi=%h lo=%h (exp %h %h) lat=%0d",
                 w, c, av, bv, mode, b2b, rd_hi(w8), rd_lo(w8), eh, el, n);
    endtask

    task automatic done_drops(input bit w8);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(rd_done(w8)), 64'(1'b0));
    endtask

    task automatic mt_write(input bit w8, input logic hw, input logic lw, input logic [31:0] wd);
        logic [31:0] ph, pl, ew;
        @(negedge clk);
        ph = rd_hi(w8);
        pl = rd_lo(w8);
        ew = w8 ? {24'h0, wd[7:0]} : wd;
        set_in(w8, 1'b0, 4'h0, 32'h0, 32'h0, hw, lw, wd);
        @(posedge clk); #1;
        set_in(w8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("mt_hi", 64'(rd_hi(w8)), 64'(hw ? ew : ph));
        check("mt_lo", 64'(rd_lo(w8)), 64'(lw ? ew : pl));
        $display("[TB] w=%0d mt hi_we=%0d lo_we=%0d wdata=%h -> hi=%h lo=%h",
                 w8 ? 8 : 32, hw, lw, wd, rd_hi(w8), rd_lo(w8));
    endtask

    task automatic illegal_code(input bit w8);
        logic [31:0] ph, pl;
        int          dones;
        @(negedge clk);
        ph = rd_hi(w8);
        pl = rd_lo(w8);
        set_in(w8, 1'b1, 4'b0010, 32'd5, 32'd3, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_in(w8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("illegal_busy", 64'(rd_busy(w8)), 64'(1'b0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rd_done(w8) === 1'b1) dones++;
        end
        check("illegal_no_done", 64'(dones), 64'(0));
        check("illegal_hi_kept", 64'(rd_hi(w8)), 64'(ph));
        check("illegal_lo_kept", 64'(rd_lo(w8)), 64'(pl));
        $display("[TB] w=%0d op=0010 ignored, busy=%0d", w8 ? 8 : 32, rd_busy(w8));
    endtask

    task automatic reset_mid_run();
        int dones;
        @(negedge clk);
        set_in(1'b0, 1'b1, 4'b1101, 32'd5, 32'd7, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_busy", 64'(bus32.busy), 64'(1'b0));
        check("rst_mid_done", 64'(bus32.done), 64'(1'b0));
        check("rst_mid_hi", 64'(bus32.hi), 64'(0));
        check("rst_mid_lo", 64'(bus32.lo), 64'(0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus32.done === 1'b1) dones++;
        end
        check("rst_mid_no_done", 64'(dones), 64'(0));
        $display("[TB] w=32 multu 5*7 reset at cycle 10 -> busy=%0d hi=%h lo=%h", bus32.busy, bus32.hi, bus32.lo);
    endtask

    task automatic directed(input bit w8);
        logic [31:0] mn, ones;
        mn   = w8 ? 32'h80 : 32'h8000_0000;
        ones = w8 ? 32'hFF : 32'hFFFF_FFFF;
        mt_write(w8, 1'b1, 1'b1, 32'h1234);
        mt_write(w8, 1'b1, 1'b0, 32'h0055);
        mt_write(w8, 1'b0, 1'b1, 32'h00AA);
        run_op(w8, 4'b1101, ones, ones, 0, 1'b0);
        done_drops(w8);
        run_op(w8, 4'b1100, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        run_op(w8, 4'b1100, mn, mn, 0, 1'b0);
        run_op(w8, 4'b1100, mn, 32'd3, 0, 1'b0);
        run_op(w8, 4'b1110, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(w8, 4'b1111, 32'd100, 32'd7, 0, 1'b0);
        run_op(w8, 4'b1111, 32'd9, 32'd0, 0, 1'b0);
        run_op(w8, 4'b1110, 32'hFFFF_FFF7, 32'd0, 0, 1'b0);
        run_op(w8, 4'b1110, mn, ones, 0, 1'b0);
        run_op(w8, 4'b1110, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        mt_write(w8, 1'b1, 1'b1, 32'h1234);
        run_op(w8, 4'b1101, 32'd11, 32'd13, 3, 1'b0);
        run_op(w8, 4'b1111, 32'd50, 32'd6, 1, 1'b0);
        run_op(w8, 4'b1100, 32'd9, 32'hFFFF_FFFB, 2, 1'b0);
        run_op(w8, 4'b1111, 32'd77, 32'd5, 0, 1'b0);
        run_op(w8, 4'b1111, 32'd100, 32'd7, 0, 1'b1);
        done_drops(w8);
        illegal_code(w8);
    endtask

    function automatic logic [31:0] pick(input bit w8);
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return w8 ? 32'hFF : 32'hFFFF_FFFF;
            2:       return w8 ? 32'h80 : 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_ops(input bit w8, input int count);
        bit b2b;
        for (int i = 0; i < count; i++) begin
            b2b = (i > 0) && ($urandom_range(0, 3) == 0);
            if (i > 0 && !b2b) done_drops(w8);
            run_op(w8, {2'b11, 2'($urandom_range(0, 3))}, pick(w8), pick(w8),
                   int'($urandom_range(0, 3)), b2b);
        end
        done_drops(w8);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        set_in(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_in(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy32", 64'(bus32.busy), 64'(1'b0));
        check("rst_done32", 64'(bus32.done), 64'(1'b0));
        check("rst_hi32", 64'(bus32.hi), 64'(0));
        check("rst_lo32", 64'(bus32.lo), 64'(0));
        check("rst_busy8", 64'(bus8.busy), 64'(1'b0));
        check("rst_done8", 64'(bus8.done), 64'(1'b0));
        check("rst_hi8", 64'(bus8.hi), 64'(0));
        check("rst_lo8", 64'(bus8.lo), 64'(0));
        $display("[TB] reset: busy=%0d done=%0d hi=%h lo=%h", bus32.busy, bus32.done, bus32.hi, bus32.lo);
        @(negedge clk);
        rst = 1'b0;

        directed(1'b0);
        directed(1'b1);
        random_ops(1'b0, 40);
        random_ops(1'b1, 40);
        reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Executes the four mult/div operations selected by the 4-bit ALU control code (1100 mult, 1101 multu, 1110 div, 1111 divu).
- Sits beside the single-cycle ALU in the execute stage. The pipeline stalls on busy and reads hi/lo for mfhi/mflo.
- Generalises the combinational ALU path to a parametrised, multi-cycle, handshaked datapath. Also supports mthi/mtlo writes.

Parameters:
- WIDTH, 32: operand width; hi and lo are each WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled on a clk edge while busy=0
- alu_control  in  4  operation code, sampled with start
- a  in  WIDTH  rs operand / dividend, sampled with start
- b  in  WIDTH  rt operand / divisor, sampled with start
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when hi/lo are updated by an operation
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy, done, hi, lo and the iteration counter all go to 0.
  - Reset applies mid-operation: the operation is abandoned and hi/lo are cleared.
- States: IDLE -> RUN -> FIX -> IDLE.
- Start acceptance:
  - Accepted only in IDLE with start=1 and alu_control[3:2]=2'b11.
  - Other codes are ignored.
  - start is ignored while busy=1.
- On acceptance:
  - Latch the op.
  - Signed ops (1100, 1110): latch |a|, |b| and the result signs.
  - Unsigned ops: latch a and b as-is.
  - Go to RUN, busy=1, counter=0.
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - counter==WIDTH-1 -> FIX.
- FIX: one cycle.
  - Mult: negate the 2*WIDTH product if the operand signs differ.
  - Div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write {hi,lo} (mult) or hi=remainder, lo=quotient (div).
  - Go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency:
  - Start accepted at edge 0.
  - hi/lo valid and done=1 after edge WIDTH+1.
  - busy is high from edge 0 through edge WIDTH+1 exclusive.
- Back-to-back: start may be asserted in the cycle done=1 (state IDLE) and is accepted.
- Divide by zero (b==0): no trap.
  - Result is hi=a (original, signed-correct), lo={WIDTH{1'b1}}.
  - Same latency as a normal divide.
- Signed overflow (div of most-negative value by -1): lo=most-negative value, hi=0. Falls out of the magnitude arithmetic; no special case.
- Most-negative operand for mult: its magnitude is representable as an unsigned WIDTH value; the product must be exact.
- mthi/mtlo writes:
  - In IDLE without an accepted start: hi_we writes hi and lo_we writes lo at that edge. Both may be asserted together.
  - While busy: writes are ignored.
  - In the same cycle as an accepted start: start wins and the write is dropped.
- hi/lo hold their value at all other times, including throughout RUN.

Test Plan:
- Reset mid-RUN: multu 5*7, rst asserted at cycle 10 -> busy=0, done=0, hi=0, lo=0 next cycle; no done pulse follows.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- mult a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu 100/7 -> lo=14, hi=2; divu 9/0 -> hi=9, lo=0xFFFFFFFF.
- Handshake:
  - start while busy -> ignored.
  - start with alu_control=0010 -> ignored, busy stays 0.
  - hi_we during RUN -> hi unchanged.
  - hi_we+lo_we in IDLE with wdata=0x1234 -> hi=lo=0x1234.
  - start plus hi_we in the same cycle -> write dropped.
- Back-to-back: second divu issued in the done cycle -> accepted; second done 33 cycles later. Repeat the directed cases with WIDTH=8 (latency 9 cycles).
